// File: rtl/hash_table_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hash_table_pkg
// Purpose  : Shared types and defaults for the data table dispatch block.
// Revision : 1.0
// ============================================================================
package hash_table_pkg;

    localparam int DEF_DIR_CNT  = 3;
    localparam int DEF_A_WIDTH  = 10;
    localparam int DEF_D_WIDTH  = 64;
    localparam int DEF_OP_WIDTH = 2;

    // Opcode d addresses engine d; anything at or beyond DIR_CNT is discarded.
    localparam logic [1:0] OP_ENG0    = 2'd0;
    localparam logic [1:0] OP_ENG1    = 2'd1;
    localparam logic [1:0] OP_ENG2    = 2'd2;
    localparam logic [1:0] OP_DISCARD = 2'd3;

    typedef enum logic [1:0] {
        CLR_IDLE  = 2'd0,
        CLR_DRAIN = 2'd1,
        CLR_CLEAR = 2'd2,
        CLR_DONE  = 2'd3
    } clr_state_e;

    function automatic logic multi_hot(input logic [31:0] v);
        return (v & (v - 32'd1)) != 32'd0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_table_clear_seq.sv
`default_nettype none
// ============================================================================
// Module   : data_table_clear_seq
// Purpose  : Drain/clear/done sequencer that zeroes the whole data RAM.
// Revision : 1.0
// ============================================================================
module data_table_clear_seq
    import hash_table_pkg::*;
#(
    parameter int DIR_CNT = DEF_DIR_CNT,
    parameter int A_WIDTH = DEF_A_WIDTH
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               clear_run_i,
    input  logic [DIR_CNT-1:0] eng_busy_i,
    output clr_state_e         state_o,
    output logic               clr_wr_en_o,
    output logic [A_WIDTH-1:0] clr_wr_addr_o,
    output logic               clear_busy_o,
    output logic               clear_done_o
);

    clr_state_e         state_q, state_d;
    logic [A_WIDTH-1:0] cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CLR_IDLE:  if (clear_run_i) state_d = CLR_DRAIN;
            CLR_DRAIN: if (eng_busy_i == '0) state_d = CLR_CLEAR;
            CLR_CLEAR: begin
                // Counter wraps back to zero on the final address.
                cnt_d = cnt_q + A_WIDTH'(1);
                if (cnt_q == '1) state_d = CLR_DONE;
            end
            CLR_DONE:  state_d = CLR_IDLE;
            default:   state_d = CLR_IDLE;
        endcase
        busy_d = (state_d != CLR_IDLE);
        done_d = (state_d == CLR_DONE);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= CLR_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign state_o       = state_q;
    assign clr_wr_en_o   = (state_q == CLR_CLEAR);
    assign clr_wr_addr_o = cnt_q;
    assign clear_busy_o  = busy_q;
    assign clear_done_o  = done_q;

endmodule
`default_nettype wire

// File: rtl/data_table_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : data_table_dispatch
// Purpose  : Task dispatch to command engines, RAM port muxing and RAM clear.
//            DATA_TABLE_COLLISION_CHK_EN enables the sticky collision flag.
// Revision : 1.0
// ============================================================================
module data_table_dispatch
    import hash_table_pkg::*;
#(
    parameter int DIR_CNT  = DEF_DIR_CNT,
    parameter int A_WIDTH  = DEF_A_WIDTH,
    parameter int D_WIDTH  = DEF_D_WIDTH,
    parameter int OP_WIDTH = DEF_OP_WIDTH
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic [OP_WIDTH-1:0]        task_opcode_i,
    input  logic                       task_valid_i,
    output logic                       task_ready_o,
    output logic [DIR_CNT-1:0]         eng_task_valid_o,
    input  logic [DIR_CNT-1:0]         eng_task_ready_i,
    input  logic [DIR_CNT-1:0]         eng_busy_i,
    input  logic [DIR_CNT*A_WIDTH-1:0] eng_rd_addr_i,
    input  logic [DIR_CNT-1:0]         eng_rd_en_i,
    input  logic [DIR_CNT*A_WIDTH-1:0] eng_wr_addr_i,
    input  logic [DIR_CNT*D_WIDTH-1:0] eng_wr_data_i,
    input  logic [DIR_CNT-1:0]         eng_wr_en_i,
    output logic [A_WIDTH-1:0]         ram_rd_addr_o,
    output logic                       ram_rd_en_o,
    output logic [A_WIDTH-1:0]         ram_wr_addr_o,
    output logic [D_WIDTH-1:0]         ram_wr_data_o,
    output logic                       ram_wr_en_o,
    input  logic                       clear_run_i,
    output logic                       clear_busy_o,
    output logic                       clear_done_o,
    output logic                       err_collision_o
);

    clr_state_e         clr_state;
    logic               clr_wr_en;
    logic [A_WIDTH-1:0] clr_wr_addr;
    logic               idle;
    logic               other_busy;

    data_table_clear_seq #(
        .DIR_CNT (DIR_CNT),
        .A_WIDTH (A_WIDTH)
    ) u_clear_seq (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .clear_run_i   (clear_run_i),
        .eng_busy_i    (eng_busy_i),
        .state_o       (clr_state),
        .clr_wr_en_o   (clr_wr_en),
        .clr_wr_addr_o (clr_wr_addr),
        .clear_busy_o  (clear_busy_o),
        .clear_done_o  (clear_done_o)
    );

    assign idle = (clr_state == CLR_IDLE);

    // A task goes out only when every other engine is quiet.
    always_comb begin
        eng_task_valid_o = '0;
        task_ready_o     = 1'b0;
        other_busy       = 1'b0;
        if (idle) begin
            if (int'(task_opcode_i) >= DIR_CNT) begin
                task_ready_o = 1'b1;
            end else begin
                for (int j = 0; j < DIR_CNT; j++) begin
                    if (j != int'(task_opcode_i) && eng_busy_i[j]) other_busy = 1'b1;
                end
                if (!other_busy) begin
                    for (int d = 0; d < DIR_CNT; d++) begin
                        if (d == int'(task_opcode_i)) begin
                            eng_task_valid_o[d] = task_valid_i;
                            task_ready_o        = eng_task_ready_i[d];
                        end
                    end
                end
            end
        end
    end

    // Descending scan so the lowest requesting index is the last to assign.
    always_comb begin
        ram_rd_en_o   = 1'b0;
        ram_rd_addr_o = '0;
        for (int i = DIR_CNT - 1; i >= 0; i--) begin
            if (eng_rd_en_i[i]) begin
                ram_rd_en_o   = 1'b1;
                ram_rd_addr_o = eng_rd_addr_i[i*A_WIDTH +: A_WIDTH];
            end
        end
    end

    always_comb begin
        ram_wr_en_o   = 1'b0;
        ram_wr_addr_o = '0;
        ram_wr_data_o = '0;
        for (int i = DIR_CNT - 1; i >= 0; i--) begin
            if (eng_wr_en_i[i]) begin
                ram_wr_en_o   = 1'b1;
                ram_wr_addr_o = eng_wr_addr_i[i*A_WIDTH +: A_WIDTH];
                ram_wr_data_o = eng_wr_data_i[i*D_WIDTH +: D_WIDTH];
            end
        end
        if (clr_wr_en) begin
            ram_wr_en_o   = 1'b1;
            ram_wr_addr_o = clr_wr_addr;
            ram_wr_data_o = '0;
        end
    end

`ifdef DATA_TABLE_COLLISION_CHK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q
              | multi_hot(32'(eng_rd_en_i))
              | multi_hot(32'(eng_wr_en_i))
              | (clr_wr_en & (|eng_wr_en_i));
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) err_q <= 1'b0;
        else          err_q <= err_d;
    end

    assign err_collision_o = err_q;
`else
    assign err_collision_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/data_table_dispatch.md
DATA_TABLE_DISPATCH -- requirements
Module: data_table_dispatch

Interface
REQ-001 Parameter DIR_CNT, default 3, number of command engines (opcode value d selects engine d).
REQ-002 Parameter A_WIDTH, default 10, data RAM address width.
REQ-003 Parameter D_WIDTH, default 64, data RAM word width.
REQ-004 Parameter OP_WIDTH, default 2, opcode width; DIR_CNT <= 2**OP_WIDTH.
REQ-005 clk_i  in  1  single clock; all logic on rising edge.
REQ-006 rst_n_i  in  1  asynchronous, active-low reset.
REQ-007 task_opcode_i  in  OP_WIDTH  opcode of the offered task.
REQ-008 task_valid_i / task_ready_o  in / out  1 / 1  task handshake.
REQ-009 eng_task_valid_o  out  DIR_CNT  per-engine task valid.
REQ-010 eng_task_ready_i / eng_busy_i  in  DIR_CNT each  per-engine ready / task-in-progress.
REQ-011 eng_rd_addr_i, eng_rd_en_i  in  DIR_CNT*A_WIDTH, DIR_CNT  flattened engine read requests.
REQ-012 eng_wr_addr_i, eng_wr_data_i, eng_wr_en_i  in  DIR_CNT*A_WIDTH, DIR_CNT*D_WIDTH, DIR_CNT  engine writes.
REQ-013 ram_rd_addr_o, ram_rd_en_o  out  A_WIDTH, 1  to RAM read port.
REQ-014 ram_wr_addr_o, ram_wr_data_o, ram_wr_en_o  out  A_WIDTH, D_WIDTH, 1  to RAM write port.
REQ-015 clear_run_i / clear_busy_o / clear_done_o  in / out / out  1 each  clear request, in progress, one-cycle completion pulse.
REQ-016 err_collision_o  out  1  sticky same-cycle port collision flag.

Function
REQ-017 Task with opcode d < DIR_CNT: eng_task_valid_o[d] = task_valid_i, task_ready_o = eng_task_ready_i[d], only when no engine j != d has eng_busy_i[j] = 1 and FSM is IDLE; otherwise both 0.
REQ-018 Opcode >= DIR_CNT: task_ready_o = 1 (task discarded), no engine valid, when FSM IDLE.
REQ-019 Read mux combinational, zero latency: lowest index with eng_rd_en_i set drives RAM read; none set -> ram_rd_en_o = 0, addr 0.
REQ-020 Write mux combinational, same lowest-index priority, except in CLEAR state where sequencer owns write port.
REQ-021 FSM states IDLE, DRAIN, CLEAR, DONE; reset state IDLE.
REQ-022 IDLE -> DRAIN on clear_run_i = 1; clear_run_i ignored in any other state.
REQ-023 DRAIN: no new tasks accepted; -> CLEAR in cycle after eng_busy_i all 0 (immediately next cycle if already 0).
REQ-024 CLEAR: registered counter from 0, one write per cycle: addr = counter, data = 0, ram_wr_en_o = 1; after address 2**A_WIDTH-1 -> DONE (exactly 2**A_WIDTH writes, counter wraps to 0).
REQ-025 DONE: clear_done_o = 1 for exactly one cycle, -> IDLE.
REQ-026 clear_busy_o = 1 in DRAIN, CLEAR, DONE.
REQ-027 Engine write during CLEAR: discarded, clear write wins.

Reset
REQ-028 On rst_n_i = 0 (asynchronous, any state, mid-clear included): FSM IDLE, counter 0, clear_done_o = 0, clear_busy_o = 0, err_collision_o = 0; combinational outputs follow inputs per REQ-017..020.
REQ-029 Clear aborted by reset is not resumed; RAM contents undefined.

Configuration
REQ-030 Macro DATA_TABLE_COLLISION_CHK_EN defined: err_collision_o sets when >1 eng_rd_en_i or >1 eng_wr_en_i high in one cycle, or any eng_wr_en_i in CLEAR; cleared only by reset.
REQ-031 Macro undefined: err_collision_o tied 0, no detection logic.

Structure
REQ-032 Opcode encoding, FSM state enum and default parameter constants in shared hash_table package.
REQ-033 One sub-module: data_table_clear_seq (FSM + counter); muxes stay in top.

Verification (DIR_CNT=3, A_WIDTH=4, D_WIDTH=8)
REQ-034 opcode 1, valid, eng_task_ready_i=3'b010, busy=0 -> eng_task_valid_o=3'b010, task_ready_o=1.
REQ-035 opcode 0 offered, eng_busy_i=3'b100 -> eng_task_valid_o=0, task_ready_o=0 until busy drops.
REQ-036 eng_rd_en_i=3'b110, addrs 5/9 -> ram_rd_addr_o=5; with macro err_collision_o=1 next cycle and stays.
REQ-037 clear_run_i pulse, busy=0 -> 16 consecutive writes addr 0..15 data 0, then clear_done_o one cycle, clear_busy_o low after.
REQ-038 clear_run_i while eng_busy_i=3'b001 for 4 cycles -> no writes until busy low, task_ready_o=0 throughout.
REQ-039 rst_n_i low at clear addr 7 -> outputs reset immediately, ram_wr_en_o=0 after release, FSM IDLE.
